serial_word_ring: RTL and testbench
===================================

// Module: serial_word_ring
// PURPOSE
//   Parametrised serial-load circular word memory: the next generation of the 8-bit serial ring.
//   Bits enter one per clock, LSB first, into a staging word. After every WORD_W bits the ring
//   rotates one word, so the freshly completed word appears on the head output.
//   Adds: width/depth parameters, true recirculation, hold/freeze, head index and frame strobes.
//   Sits behind the 8-bit IO pins and drives a display or LED bank from the head word.
// PARAMETERS
//   WORD_W      8   bits per word; legal range >= 2
//   WORD_COUNT  22  words in the ring; legal range >= 3
// PORTS
//   clk          in   1                     rising-edge clock
//   reset        in   1                     synchronous, active-high reset
//   write        in   1                     1: shift din into staging; 0: recirculate staging LSB
//   din          in   1                     serial data bit
//   hold         in   1                     1: freeze all state (counters, ring)
//   io_out       out  WORD_W                head word (ring word 0)
//   head_idx     out  $clog2(WORD_COUNT)    rotation count mod WORD_COUNT
//   word_strobe  out  1                     1-cycle pulse, registered with each rotation
//   frame_start  out  1                     1-cycle pulse when head_idx wraps to 0
// BEHAVIOUR
//   - Ring storage: words w[0..WORD_COUNT-1]. w[0] is the head (io_out); w[1] is the staging word.
//   - Shift, on each clk with hold=0:
//       w[1] <= {bh, w[1][WORD_W-1:1]}, where bh = write ? din : w[1][0]
//       (true rotate; a stored word survives a read pass unchanged)
//   - bit_cnt counts 0..WORD_W-1. On the clock where bit_cnt==WORD_W-1, rotate instead of shift:
//       w[0] <= shifted w[1]; w[k] <= w[k+1] for k=1..N-2; w[N-1] <= old w[0]
//       bit_cnt <= 0; head_idx <= head_idx+1 (wraps N-1 -> 0)
//   - Strobes are registered: word_strobe is high for the cycle after each rotation.
//     frame_start is high in that same cycle only when the new head_idx is 0.
//   - Latency: the Nth written word is on io_out 0 cycles after the clock carrying its last bit.
//   - hold=1: nothing changes and din is ignored; strobes are forced to 0. hold takes priority
//     over write.
//   - reset=1 (sync), at any point including mid-word: all words <= 0; bit_cnt, head_idx <= 0;
//     word_strobe, frame_start <= 0; io_out = 0. The partial word is discarded. reset takes
//     priority over hold.
//   - write may change on any bit; a word can mix written and recirculated bits.
// CONFIGURATION
//   SERIAL_RING_DOUT_EN defined:
//     - Adds port dout (out, 1) = w[1][0], the bit leaving staging on the next shift.
//     - Reads stored words back LSB-first when write=0; allows daisy-chaining rings.
//     - dout is 0 during and after reset.
//   SERIAL_RING_DOUT_EN undefined: no dout port and no extra logic.
// STRUCTURE
//   - Package serial_ring_pkg holds:
//       typedef for the word type, derived from WORD_W
//       the function idx_w(n) = max(1, $clog2(n))
//       the rotate-vs-shift select encoding
//   - Sub-module ring_mod_counter: modulo-M counter with enable, sync reset and a terminal-count
//     flag. Instantiated twice: bit_cnt (M=WORD_W) and head_idx (M=WORD_COUNT).
//   - Ring storage is a flat register array in the top module.
// TESTING (WORD_W=8, WORD_COUNT=4 unless noted)
//   1. Reset, then write=1 with din=1,0,1,0,0,1,0,1 -> io_out=0xA5 after the 8th clk;
//      word_strobe=1 in the next cycle; head_idx=1.
//   2. Write 0x11,0x22,0x33,0x44, then write=0 for 64 clks -> io_out steps 0x44,0x11,0x22,0x33,
//      0x44,... every 8 clks; data is unchanged after a full pass.
//   3. Assert hold after 3 bits of 0x5A for 5 clks while din toggles -> io_out, bit_cnt, head_idx
//      frozen; after release, the last 5 bits complete 0x5A.
//   4. Reset asserted at bit 3 of a word -> next cycle io_out=0, head_idx=0, strobes=0;
//      a subsequent 8-bit write of 0xC3 lands correctly.
//   5. Free-run 40 clks with write=1, din=0 -> head_idx 1,2,3,0,1; frame_start pulses exactly
//      at clk 33 (the cycle after the 4th rotation).
//   6. SERIAL_RING_DOUT_EN, staging=0x96, write=0 -> dout over 8 clks = 0,1,1,0,1,0,0,1.

Source files
------------

// File: rtl/serial_ring_pkg.sv
// Shared types and helpers for the serial word ring.
package serial_ring_pkg;

  localparam int unsigned DEF_WORD_W     = 8;
  localparam int unsigned DEF_WORD_COUNT = 22;

  // Word type at the default width. Parameterised instances use a local typedef of the same shape.
  typedef logic [DEF_WORD_W-1:0] word_t;

  // Staging either takes one more bit or hands its completed word to the head.
  typedef enum logic {
    SEL_SHIFT  = 1'b0,
    SEL_ROTATE = 1'b1
  } ring_sel_e;

  // Index width for a count of n; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    if (n > 32'd2) return $unsigned($clog2(n));
    return 32'd1;
  endfunction

endpackage

// File: rtl/serial_word_ring_counter.sv
// Modulo-M counter with enable, synchronous reset and a terminal-count flag.
module ring_mod_counter
  import serial_ring_pkg::*;
#(
  parameter int unsigned M = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  output logic [idx_w(M)-1:0]  count,
  output logic                 last_c
);

  localparam int unsigned CW = idx_w(M);
  localparam logic [CW-1:0] TOP = CW'(M - 1);

  assign last_c = (count == TOP);

  // Advance when enabled, wrapping from M-1 back to 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (en) begin
      count <= last_c ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/serial_word_ring.sv
// Serial-load circular word memory: bits enter LSB first into a staging word and the ring
// rotates once per completed word, placing that word on io_out.
// Optional feature: define SERIAL_RING_DOUT_EN to add the dout port (staging LSB).
module serial_word_ring
  import serial_ring_pkg::*;
#(
  parameter int unsigned WORD_W     = DEF_WORD_W,
  parameter int unsigned WORD_COUNT = DEF_WORD_COUNT
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           write,
  input  logic                           din,
  input  logic                           hold,
  output logic [WORD_W-1:0]              io_out,
  output logic [idx_w(WORD_COUNT)-1:0]   head_idx,
  output logic                           word_strobe,
  output logic                           frame_start
`ifdef SERIAL_RING_DOUT_EN
  ,
  output logic                           dout
`endif
);

  localparam int unsigned BIT_CW = idx_w(WORD_W);
  localparam int unsigned IDX_W  = idx_w(WORD_COUNT);

  typedef logic [WORD_W-1:0] ring_word_t;

  ring_word_t        ring [WORD_COUNT];
  logic [BIT_CW-1:0] bit_cnt;
  logic [IDX_W-1:0]  head_cnt;
  logic              bit_last_c;
  logic              head_last_c;
  logic              head_en_c;
  logic              bh_c;
  ring_word_t        shifted_c;
  ring_sel_e         sel_c;

  assign head_en_c = ~hold & bit_last_c;

  ring_mod_counter #(.M(WORD_W)) u_bit_cnt (
    .clk    (clk),
    .reset  (reset),
    .en     (~hold),
    .count  (bit_cnt),
    .last_c (bit_last_c)
  );

  ring_mod_counter #(.M(WORD_COUNT)) u_head_cnt (
    .clk    (clk),
    .reset  (reset),
    .en     (head_en_c),
    .count  (head_cnt),
    .last_c (head_last_c)
  );

  // Next staging value and whether this clock completes a word.
  always_comb begin
    bh_c      = ring[1][0];
    shifted_c = ring[1];
    sel_c     = SEL_SHIFT;
    if (write) bh_c = din;
    shifted_c = {bh_c, ring[1][WORD_W-1:1]};
    if (bit_last_c) sel_c = SEL_ROTATE;
  end

  // Ring storage and strobes; reset beats hold, hold freezes everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < WORD_COUNT; k++) ring[k] <= '0;
      word_strobe <= 1'b0;
      frame_start <= 1'b0;
    end else if (hold) begin
      word_strobe <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      case (sel_c)
        SEL_ROTATE: begin
          ring[0] <= shifted_c;
          for (int unsigned k = 1; k < WORD_COUNT - 1; k++) ring[k] <= ring[k+1];
          ring[WORD_COUNT-1] <= ring[0];
        end
        default: ring[1] <= shifted_c;
      endcase
      word_strobe <= (sel_c == SEL_ROTATE);
      frame_start <= (sel_c == SEL_ROTATE) && head_last_c;
    end
  end

  assign io_out   = ring[0];
  assign head_idx = head_cnt;

`ifdef SERIAL_RING_DOUT_EN
  assign dout = ring[1][0];
`endif

endmodule

// File: tb/tb_serial_word_ring.sv
// Self-checking bench for serial_word_ring (WORD_W=8, WORD_COUNT=4) against a queue-based model.
// Honours SERIAL_RING_DOUT_EN to connect and check dout.
module tb_serial_word_ring;

  localparam int W = 8;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset, write, din, hold;
  logic [7:0] io_out;
  logic [1:0] head_idx;
  logic       word_strobe, frame_start;
`ifdef SERIAL_RING_DOUT_EN
  logic       dout;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Model: queue ordered head, staging, then the rest of the ring.
  logic [7:0] mq[$];
  int         m_cnt, m_head;
  logic       m_ws, m_fs;

  serial_word_ring #(.WORD_W(W), .WORD_COUNT(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .write       (write),
    .din         (din),
    .hold        (hold),
    .io_out      (io_out),
    .head_idx    (head_idx),
    .word_strobe (word_strobe),
    .frame_start (frame_start)
`ifdef SERIAL_RING_DOUT_EN
    ,
    .dout        (dout)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // One clock of stimulus, with the model advanced by the same rules.
  task automatic tick(input logic w, input logic d, input logic h, input logic r);
    logic       b;
    logic [7:0] st, old;
    write = w; din = d; hold = h; reset = r;
    @(posedge clk);
    if (r) begin
      mq.delete();
      for (int i = 0; i < N; i++) mq.push_back(8'h00);
      m_cnt = 0; m_head = 0; m_ws = 1'b0; m_fs = 1'b0;
    end else if (h) begin
      m_ws = 1'b0; m_fs = 1'b0;
    end else begin
      b  = w ? d : mq[1][0];
      st = (mq[1] >> 1) | (8'(b) << 7);
      if (m_cnt == W - 1) begin
        old = mq.pop_front();
        void'(mq.pop_front());
        mq.push_front(st);
        mq.push_back(old);
        m_cnt  = 0;
        m_head = (m_head + 1) % N;
        m_ws   = 1'b1;
        m_fs   = (m_head == 0);
      end else begin
        mq[1] = st;
        m_cnt = m_cnt + 1;
        m_ws  = 1'b0;
        m_fs  = 1'b0;
      end
    end
    #1;
  endtask

  task automatic send_word(input logic [7:0] v);
    for (int i = 0; i < W; i++) tick(1'b1, v[i], 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++; if (io_out !== 8'h00) begin n_errors++; $display("FAIL reset_io: got %h want 00", io_out); end
    n_checks++; if (head_idx !== 2'd0) begin n_errors++; $display("FAIL reset_head: got %0d want 0", head_idx); end
    n_checks++; if (word_strobe !== 1'b0 || frame_start !== 1'b0) begin n_errors++; $display("FAIL reset_strobes: got %b%b want 00", word_strobe, frame_start); end
`ifdef SERIAL_RING_DOUT_EN
    n_checks++; if (dout !== 1'b0) begin n_errors++; $display("FAIL reset_dout: got %b want 0", dout); end
`endif
  endtask

  task automatic test_single_word();
    logic [7:0] bits;
    bits = 8'hA5;
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < W; i++) begin
      tick(1'b1, bits[i], 1'b0, 1'b0);
      if (i < W - 1) begin
        n_checks++; if (word_strobe !== 1'b0 || io_out !== 8'h00) begin n_errors++; $display("FAIL single_early: bit %0d got io %h ws %b want 00 0", i, io_out, word_strobe); end
      end
    end
    n_checks++; if (io_out !== 8'hA5) begin n_errors++; $display("FAIL single_io: got %h want a5", io_out); end
    n_checks++; if (word_strobe !== 1'b1) begin n_errors++; $display("FAIL single_ws: got %b want 1", word_strobe); end
    n_checks++; if (head_idx !== 2'd1) begin n_errors++; $display("FAIL single_head: got %0d want 1", head_idx); end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++; if (word_strobe !== 1'b0) begin n_errors++; $display("FAIL single_ws_pulse: got %b want 0", word_strobe); end
  endtask

  task automatic test_recirculate();
    logic [7:0] seq [4];
    seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) send_word(seq[k]);
    n_checks++; if (io_out !== 8'h44) begin n_errors++; $display("FAIL recirc_start: got %h want 44", io_out); end
    for (int i = 1; i <= 64; i++) begin
      tick(1'b0, 1'($urandom_range(1)), 1'b0, 1'b0);
      n_checks++; if (io_out !== mq[0]) begin n_errors++; $display("FAIL recirc_model: clk %0d got %h want %h", i, io_out, mq[0]); end
      if (i % 8 == 0) begin
        n_checks++; if (io_out !== seq[(i / 8 - 1) % 4] || word_strobe !== 1'b1) begin n_errors++; $display("FAIL recirc_seq: clk %0d got %h ws %b want %h 1", i, io_out, word_strobe, seq[(i / 8 - 1) % 4]); end
      end
    end
  endtask

  task automatic test_hold();
    logic [7:0] v;
    v = 8'h5A;
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    send_word(8'h3C);
    for (int i = 0; i < 3; i++) tick(1'b1, v[i], 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1'($urandom_range(1)), 1'(i & 1), 1'b1, 1'b0);
      n_checks++; if (io_out !== 8'h3C || head_idx !== 2'd1 || word_strobe !== 1'b0) begin n_errors++; $display("FAIL hold_frozen: got io %h head %0d ws %b want 3c 1 0", io_out, head_idx, word_strobe); end
    end
    for (int i = 3; i < 7; i++) tick(1'b1, v[i], 1'b0, 1'b0);
    n_checks++; if (io_out !== 8'h3C) begin n_errors++; $display("FAIL hold_cnt_frozen: got %h want 3c", io_out); end
    tick(1'b1, v[7], 1'b0, 1'b0);
    n_checks++; if (io_out !== 8'h5A || head_idx !== 2'd2 || word_strobe !== 1'b1) begin n_errors++; $display("FAIL hold_complete: got io %h head %0d ws %b want 5a 2 1", io_out, head_idx, word_strobe); end
  endtask

  task automatic test_reset_midword();
    logic [7:0] v;
    v = 8'hC3;
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    send_word(8'h77);
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    n_checks++; if (io_out !== 8'h00 || head_idx !== 2'd0) begin n_errors++; $display("FAIL midreset_clear: got io %h head %0d want 00 0", io_out, head_idx); end
    n_checks++; if (word_strobe !== 1'b0 || frame_start !== 1'b0) begin n_errors++; $display("FAIL midreset_strobes: got %b%b want 00", word_strobe, frame_start); end
    for (int i = 0; i < W; i++) tick(1'b1, v[i], 1'b0, 1'b0);
    n_checks++; if (io_out !== 8'hC3 || head_idx !== 2'd1) begin n_errors++; $display("FAIL midreset_word: got io %h head %0d want c3 1", io_out, head_idx); end
  endtask

  task automatic test_free_run();
    int fs_count;
    fs_count = 0;
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 40; i++) begin
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      if (frame_start === 1'b1) fs_count++;
      n_checks++; if (frame_start !== (i == 32)) begin n_errors++; $display("FAIL free_fs: clk %0d got %b want %b", i, frame_start, (i == 32)); end
      n_checks++; if (word_strobe !== (i % 8 == 0)) begin n_errors++; $display("FAIL free_ws: clk %0d got %b want %b", i, word_strobe, (i % 8 == 0)); end
      n_checks++; if (head_idx !== 2'((i / 8) % 4)) begin n_errors++; $display("FAIL free_head: clk %0d got %0d want %0d", i, head_idx, (i / 8) % 4); end
    end
    n_checks++; if (fs_count != 1) begin n_errors++; $display("FAIL free_fs_count: got %0d want 1", fs_count); end
  endtask

  task automatic test_random();
    logic r, h;
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(63) == 0);
      h = ($urandom_range(7) == 0);
      tick(1'($urandom_range(3) != 0), 1'($urandom_range(1)), h, r);
      n_checks++;
      if (io_out !== mq[0] || head_idx !== 2'(m_head) || word_strobe !== m_ws || frame_start !== m_fs) begin
        n_errors++;
        $display("FAIL random: step %0d got io %h head %0d ws %b fs %b want %h %0d %b %b", i, io_out, head_idx, word_strobe, frame_start, mq[0], m_head, m_ws, m_fs);
      end
`ifdef SERIAL_RING_DOUT_EN
      n_checks++; if (dout !== mq[1][0]) begin n_errors++; $display("FAIL random_dout: step %0d got %b want %b", i, dout, mq[1][0]); end
`endif
    end
  endtask

`ifdef SERIAL_RING_DOUT_EN
  task automatic test_dout();
    logic [7:0] pat;
    pat = 8'h96;
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    send_word(pat);
    send_word(8'hA1);
    send_word(8'hB2);
    send_word(8'hC3);
    for (int i = 0; i < W; i++) begin
      n_checks++; if (dout !== pat[i]) begin n_errors++; $display("FAIL dout_seq: bit %0d got %b want %b", i, dout, pat[i]); end
      tick(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask
`endif

  initial begin
    reset = 1'b1; write = 1'b0; din = 1'b0; hold = 1'b0;
    mq.delete();
    for (int i = 0; i < N; i++) mq.push_back(8'h00);
    m_cnt = 0; m_head = 0; m_ws = 1'b0; m_fs = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_word();
    test_recirculate();
    test_hold();
    test_reset_midword();
    test_free_run();
`ifdef SERIAL_RING_DOUT_EN
    test_dout();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
